id_stage: RTL and testbench
===========================

# id_stage

Instruction decode stage for the RV32I core: decodes one 32-bit instruction per handshake into an `alu_op_t` operation and two 32-bit operands, and registers them in the ID/EX pipeline register that feeds the execute-stage ALU. Contains the architectural register file and its write-back port. Supports integer register-register (OP), register-immediate (OP-IMM) and LUI; everything else is flagged illegal.

## Interface
- `XLEN`, 32, datapath width; fixed at 32 for RV32I.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `in_valid`  in  1  instruction/PC present.
- `in_ready`  out  1  stage can accept an instruction this cycle.
- `in_instr`  in  32  instruction word.
- `in_pc`  in  32  instruction address, passed through.
- `flush`  in  1  discard the registered instruction and any instruction accepted this cycle.
- `wb_en`  in  1  register-file write enable.
- `wb_rd`  in  5  write address.
- `wb_data`  in  32  write data.
- `out_valid`  out  1  ID/EX register holds a decoded instruction.
- `out_ready`  in  1  execute stage consumes it.
- `out_op`  out  `alu_op_t`  ALU operation.
- `out_opr_a`, `out_opr_b`  out  32  ALU operands.
- `out_rd`  out  5  destination register.
- `out_we`  out  1  destination is written.
- `out_illegal`  out  1  unsupported/illegal encoding.
- `out_pc`  out  32  registered PC.

## Operation
- OP (0x33): op from funct3/funct7; funct7 0x20 legal only for funct3 0 (SUB) and 5 (SRA); any other funct7 ≠ 0 is illegal. opr_a = rs1 value, opr_b = rs2 value.
- OP-IMM (0x13): opr_b = sign-extended imm[11:0]; funct3 0 ADD, 2 SLT, 3 SLTU, 4 XOR, 6 OR, 7 AND. Shifts (funct3 1/5): opr_b = {27'b0, shamt}; funct7 must be 0x00 (SLL/SRL) or 0x20 (SRA, funct3 5 only), else illegal.
- Register-register shifts: opr_b = {27'b0, rs2_value[4:0]}; ALU shifts by the full opr_b.
- LUI (0x37): op ADD, opr_a 0, opr_b {imm[31:12], 12'b0}.
- Illegal: out_illegal 1, out_we 0, op ADD, operands 0; out_valid still asserted so the exception propagates.
- out_we = 1 for legal instructions with rd ≠ 0.
- Register file: 32×32, x0 reads 0 always; writes to x0 ignored; synchronous write on `clk` when `wb_en`; combinational read.
- Handshake: `in_ready = !out_valid || out_ready`. Accept when `in_valid && in_ready`; outputs hold stable while `out_valid && !out_ready`.
- `flush` has priority: next edge out_valid = 0 regardless of acceptance.

## Timing
- Reset: out_valid 0, out_op ADD, all other outputs 0, all registers 0; in_ready 1 after reset.
- Latency 1: instruction accepted at edge N is on the outputs after edge N.
- Throughput 1 per cycle when out_ready held high.
- Same-edge write-back and read of the same register: behaviour set by Configuration.
- Reset mid-stall: output register and register file clear immediately.

## Configuration
- `ID_BYPASS_EN` defined: a read of rs1/rs2 equal to `wb_rd` with `wb_en` and `wb_rd ≠ 0` returns `wb_data` in the same cycle.
- Undefined: read returns the pre-write value; hazard resolution is upstream's responsibility.

## Structure
- `alu_pkg`: existing `alu_op_t`. New `rv32i_pkg`: opcode constants (OP, OP_IMM, LUI), funct3 values, funct7 constants 0x00/0x20.
- Sub-module `reg_file` (2 read, 1 write, x0 hardwired, async reset); decode logic and ID/EX register stay in `id_stage`.

## Test plan
- Write x1 = 5 via wb, then in_instr 0x00500093 (ADDI x1,x0,5) -> next cycle out_op ADD, opr_a 0, opr_b 5, rd 1, we 1.
- x1 = 7, x2 = 3; 0x002081B3 (ADD x3,x1,x2) -> opr_a 7, opr_b 3, rd 3.
- x1 = 0x80000000; 0x4030D213 (SRAI x4,x1,3) -> op SRA, opr_b 3.
- 0x123452B7 (LUI x5) -> op ADD, opr_a 0, opr_b 0x12345000; 0x00002003 (load) -> out_illegal 1, we 0.
- out_ready low 3 cycles with in_valid high -> in_ready 0, outputs stable; flush during stall -> out_valid 0 next cycle.
- wb x2 = 0xAA in the same cycle ADD reads x2 -> opr_b 0xAA with `ID_BYPASS_EN`, old value without.

Source files
------------

// File: rtl/alu_pkg.sv
// ALU operation encoding shared by the decode and execute stages.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_t;

endpackage

// File: rtl/rv32i_pkg.sv
// RV32I encoding constants for the integer OP, OP-IMM and LUI subset.
package rv32i_pkg;
  import alu_pkg::*;

  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_LUI    = 7'h37;

  localparam logic [2:0] F3_ADD  = 3'd0;
  localparam logic [2:0] F3_SLL  = 3'd1;
  localparam logic [2:0] F3_SLT  = 3'd2;
  localparam logic [2:0] F3_SLTU = 3'd3;
  localparam logic [2:0] F3_XOR  = 3'd4;
  localparam logic [2:0] F3_SR   = 3'd5;
  localparam logic [2:0] F3_OR   = 3'd6;
  localparam logic [2:0] F3_AND  = 3'd7;

  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

  // Operation selected by funct3 alone (funct7 = 0x00 variants).
  function automatic alu_op_t base_op(input logic [2:0] funct3);
    alu_op_t op;
    case (funct3)
      F3_ADD:  op = ALU_ADD;
      F3_SLL:  op = ALU_SLL;
      F3_SLT:  op = ALU_SLT;
      F3_SLTU: op = ALU_SLTU;
      F3_XOR:  op = ALU_XOR;
      F3_SR:   op = ALU_SRL;
      F3_OR:   op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/reg_file.sv
// 32x32 architectural register file: 2 combinational reads, 1 synchronous write, x0 hardwired.
// ID_BYPASS_EN: forward same-cycle write data to matching reads.
module reg_file #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      raddr_a,
  output logic [XLEN-1:0] rdata_a,
  input  logic [4:0]      raddr_b,
  output logic [XLEN-1:0] rdata_b,
  input  logic            wen,
  input  logic [4:0]      waddr,
  input  logic [XLEN-1:0] wdata
);

  logic [XLEN-1:0] regs [32];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wen && (waddr != 5'd0)) begin
      regs[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata_a = (raddr_a == 5'd0) ? '0 : regs[raddr_a];
    rdata_b = (raddr_b == 5'd0) ? '0 : regs[raddr_b];
`ifdef ID_BYPASS_EN
    if (wen && (waddr != 5'd0) && (waddr == raddr_a)) rdata_a = wdata;
    if (wen && (waddr != 5'd0) && (waddr == raddr_b)) rdata_b = wdata;
`endif
  end

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: decodes OP/OP-IMM/LUI into ALU op + operands and holds them in the ID/EX
// register. Same-cycle write-back forwarding is selected by ID_BYPASS_EN (see reg_file).
module id_stage
  import alu_pkg::*;
  import rv32i_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output alu_op_t         out_op,
  output logic [XLEN-1:0] out_opr_a,
  output logic [XLEN-1:0] out_opr_b,
  output logic [4:0]      out_rd,
  output logic            out_we,
  output logic            out_illegal,
  output logic [XLEN-1:0] out_pc
);

  logic [6:0]      opcode, funct7;
  logic [2:0]      funct3;
  logic [4:0]      rd, rs1, rs2;
  logic [XLEN-1:0] rs1_val, rs2_val;

  assign opcode = in_instr[6:0];
  assign rd     = in_instr[11:7];
  assign funct3 = in_instr[14:12];
  assign rs1    = in_instr[19:15];
  assign rs2    = in_instr[24:20];
  assign funct7 = in_instr[31:25];

  reg_file #(
    .XLEN (XLEN)
  ) u_reg_file (
    .clk     (clk),
    .rst     (rst),
    .raddr_a (rs1),
    .rdata_a (rs1_val),
    .raddr_b (rs2),
    .rdata_b (rs2_val),
    .wen     (wb_en),
    .waddr   (wb_rd),
    .wdata   (wb_data)
  );

  alu_op_t         dec_op;
  logic [XLEN-1:0] dec_a, dec_b;
  logic            dec_legal, dec_we;

  always_comb begin
    dec_op    = ALU_ADD;
    dec_a     = '0;
    dec_b     = '0;
    dec_legal = 1'b0;
    case (opcode)
      OPC_OP: begin
        dec_a = rs1_val;
        // Register shifts only use the low five bits of rs2.
        dec_b = ((funct3 == F3_SLL) || (funct3 == F3_SR)) ?
                {{(XLEN-5){1'b0}}, rs2_val[4:0]} : rs2_val;
        if (funct7 == F7_BASE) begin
          dec_legal = 1'b1;
          dec_op    = base_op(funct3);
        end else if ((funct7 == F7_ALT) && (funct3 == F3_ADD)) begin
          dec_legal = 1'b1;
          dec_op    = ALU_SUB;
        end else if ((funct7 == F7_ALT) && (funct3 == F3_SR)) begin
          dec_legal = 1'b1;
          dec_op    = ALU_SRA;
        end
      end
      OPC_OP_IMM: begin
        dec_a = rs1_val;
        if (funct3 == F3_SLL) begin
          dec_b     = {{(XLEN-5){1'b0}}, rs2};
          dec_legal = (funct7 == F7_BASE);
          dec_op    = ALU_SLL;
        end else if (funct3 == F3_SR) begin
          dec_b     = {{(XLEN-5){1'b0}}, rs2};
          dec_legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
          dec_op    = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
        end else begin
          dec_b     = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
          dec_legal = 1'b1;
          dec_op    = base_op(funct3);
        end
      end
      OPC_LUI: begin
        dec_legal = 1'b1;
        dec_b     = {in_instr[31:12], 12'b0};
      end
      default: ;
    endcase
    // Illegal encodings travel as a harmless ADD 0,0 with the illegal flag set.
    if (!dec_legal) begin
      dec_op = ALU_ADD;
      dec_a  = '0;
      dec_b  = '0;
    end
    dec_we = dec_legal && (rd != 5'd0);
  end

  logic accept;
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_op      <= ALU_ADD;
      out_opr_a   <= '0;
      out_opr_b   <= '0;
      out_rd      <= '0;
      out_we      <= 1'b0;
      out_illegal <= 1'b0;
      out_pc      <= '0;
    end else begin
      if (flush)          out_valid <= 1'b0;
      else if (accept)    out_valid <= 1'b1;
      else if (out_ready) out_valid <= 1'b0;

      if (accept && !flush) begin
        out_op      <= dec_op;
        out_opr_a   <= dec_a;
        out_opr_b   <= dec_b;
        out_rd      <= dec_legal ? rd : 5'd0;
        out_we      <= dec_we;
        out_illegal <= !dec_legal;
        out_pc      <= in_pc;
      end
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed test-plan cases plus randomized traffic against
// a behavioural decode/pipeline model.
module tb_id_stage;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, flush, wb_en, out_valid, out_ready, out_we, out_illegal;
  logic [31:0] in_instr, in_pc, wb_data, out_opr_a, out_opr_b, out_pc;
  logic [4:0]  wb_rd, out_rd;
  alu_op_t     out_op;

  always #5 clk = ~clk;

  id_stage #(
    .XLEN (32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_pc       (in_pc),
    .flush       (flush),
    .wb_en       (wb_en),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_op      (out_op),
    .out_opr_a   (out_opr_a),
    .out_opr_b   (out_opr_b),
    .out_rd      (out_rd),
    .out_we      (out_we),
    .out_illegal (out_illegal),
    .out_pc      (out_pc)
  );

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic        illegal;
    alu_op_t     op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        we;
  } dec_t;

  // Model state: architectural registers and the ID/EX slot.
  logic [31:0] m_regs [32];
  logic        m_valid;
  dec_t        m_dec;
  logic [31:0] m_pc;

  function automatic logic [31:0] m_read(input logic [4:0] r);
    if (r == 5'd0) return 32'd0;
`ifdef ID_BYPASS_EN
    if (wb_en && (wb_rd == r)) return wb_data;
`endif
    return m_regs[r];
  endfunction

  function automatic dec_t ref_decode(input logic [31:0] w, input logic [31:0] v1,
                                      input logic [31:0] v2);
    dec_t    d;
    alu_op_t tbl [8];
    int      f3, f7;
    logic    ok;
    tbl = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
    f3  = int'(w[14:12]);
    f7  = int'(w[31:25]);
    d   = '0;
    ok  = 1'b0;
    d.op = ALU_ADD;
    if (w[6:0] == 7'h33) begin
      d.a = v1;
      d.b = (f3 == 1 || f3 == 5) ? (v2 % 32) : v2;
      if (f7 == 0) begin ok = 1'b1; d.op = tbl[f3]; end
      else if (f7 == 32 && f3 == 0) begin ok = 1'b1; d.op = ALU_SUB; end
      else if (f7 == 32 && f3 == 5) begin ok = 1'b1; d.op = ALU_SRA; end
    end else if (w[6:0] == 7'h13) begin
      d.a = v1;
      if (f3 == 1 || f3 == 5) begin
        d.b  = 32'(w[24:20]);
        ok   = (f7 == 0) || (f7 == 32 && f3 == 5);
        d.op = (f7 == 32) ? ALU_SRA : tbl[f3];
      end else begin
        d.b  = 32'($signed(w[31:20]));
        ok   = 1'b1;
        d.op = tbl[f3];
      end
    end else if (w[6:0] == 7'h37) begin
      ok  = 1'b1;
      d.b = w & 32'hFFFF_F000;
    end
    if (ok) begin
      d.rd = w[11:7];
      d.we = (w[11:7] != 5'd0);
    end else begin
      d         = '0;
      d.op      = ALU_ADD;
      d.illegal = 1'b1;
    end
    return d;
  endfunction

  task automatic check_outputs();
    check("out_valid", out_valid, m_valid);
    if (m_valid) begin
      check("out_op", out_op, m_dec.op);
      check("out_opr_a", out_opr_a, m_dec.a);
      check("out_opr_b", out_opr_b, m_dec.b);
      check("out_rd", out_rd, m_dec.rd);
      check("out_we", out_we, m_dec.we);
      check("out_illegal", out_illegal, m_dec.illegal);
      check("out_pc", out_pc, m_pc);
    end
  endtask

  // Runs one clock: drive, check in_ready, advance the model, check the registered outputs.
  task automatic cycle(input logic iv, input logic [31:0] w, input logic ordy, input logic fl,
                       input logic wen, input logic [4:0] wrd, input logic [31:0] wdat);
    logic        acc;
    dec_t        d;
    logic [31:0] pc;
    pc        = $urandom;
    in_valid  = iv;
    in_instr  = w;
    in_pc     = pc;
    out_ready = ordy;
    flush     = fl;
    wb_en     = wen;
    wb_rd     = wrd;
    wb_data   = wdat;
    #1;
    check("in_ready", in_ready, !m_valid || ordy);
    acc = iv && (!m_valid || ordy);
    d   = ref_decode(w, m_read(w[19:15]), m_read(w[24:20]));
    @(posedge clk);
    if (wen && wrd != 5'd0) m_regs[wrd] = wdat;
    if (fl) m_valid = 1'b0;
    else if (acc) begin m_valid = 1'b1; m_dec = d; m_pc = pc; end
    else if (ordy) m_valid = 1'b0;
    #1;
    check_outputs();
  endtask

  task automatic wb_write(input logic [4:0] r, input logic [31:0] v);
    cycle(1'b0, 32'd0, 1'b1, 1'b0, 1'b1, r, v);
  endtask

  function automatic logic [6:0] pick_f7();
    int unsigned k = $urandom_range(0, 3);
    if (k < 2) return 7'h00;
    if (k == 2) return 7'h20;
    return 7'($urandom);
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w = $urandom;
    case ($urandom_range(0, 3))
      0: begin w[6:0] = 7'h33; w[31:25] = pick_f7(); end
      1: begin
        w[6:0] = 7'h13;
        if (w[13:12] == 2'b01) w[31:25] = pick_f7();
      end
      2: w[6:0] = 7'h37;
      default: ;
    endcase
    return w;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 0; in_instr = 0; in_pc = 0; flush = 0;
    wb_en = 0; wb_rd = 0; wb_data = 0; out_ready = 1;
    clear_model();
    m_dec = '0;
    m_pc  = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_op", out_op, ALU_ADD);
    check("rst_out_opr_a", out_opr_a, 0);
    check("rst_out_opr_b", out_opr_b, 0);
    check("rst_out_rd", out_rd, 0);
    check("rst_out_we", out_we, 0);
    check("rst_out_illegal", out_illegal, 0);
    check("rst_out_pc", out_pc, 0);
    check("rst_in_ready", in_ready, 1);
    rst = 1'b0;

    // ADDI x1,x0,5 after writing x1 = 5
    wb_write(5'd1, 32'd5);
    cycle(1, 32'h0050_0093, 1, 0, 0, 0, 0);
    check("addi_op", out_op, ALU_ADD);
    check("addi_a", out_opr_a, 0);
    check("addi_b", out_opr_b, 5);
    check("addi_rd", out_rd, 1);
    check("addi_we", out_we, 1);

    // ADD x3,x1,x2
    wb_write(5'd1, 32'd7);
    wb_write(5'd2, 32'd3);
    cycle(1, 32'h0020_81B3, 1, 0, 0, 0, 0);
    check("add_a", out_opr_a, 7);
    check("add_b", out_opr_b, 3);
    check("add_rd", out_rd, 3);

    // SRAI x4,x1,3
    wb_write(5'd1, 32'h8000_0000);
    cycle(1, 32'h4030_D213, 1, 0, 0, 0, 0);
    check("srai_op", out_op, ALU_SRA);
    check("srai_b", out_opr_b, 3);

    // LUI and an unsupported load
    cycle(1, 32'h1234_52B7, 1, 0, 0, 0, 0);
    check("lui_op", out_op, ALU_ADD);
    check("lui_a", out_opr_a, 0);
    check("lui_b", out_opr_b, 32'h1234_5000);
    cycle(1, 32'h0000_2003, 1, 0, 0, 0, 0);
    check("load_illegal", out_illegal, 1);
    check("load_we", out_we, 0);
    check("load_valid", out_valid, 1);

    // Stall three cycles, then flush during the stall
    cycle(1, 32'h0020_81B3, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(1, rand_instr(), 0, 0, 0, 0, 0);
      check("stall_in_ready", in_ready, 0);
    end
    cycle(1, rand_instr(), 0, 1, 0, 0, 0);
    check("flush_valid", out_valid, 0);

    // Same-edge write-back of x2 while ADD reads x2
    wb_write(5'd2, 32'h11);
    cycle(1, 32'h0020_81B3, 1, 0, 1, 5'd2, 32'hAA);
`ifdef ID_BYPASS_EN
    check("bypass_b", out_opr_b, 32'hAA);
`else
    check("bypass_b", out_opr_b, 32'h11);
`endif

    // Reset asserted mid-stall clears state without waiting for an edge
    cycle(1, 32'h0020_81B3, 1, 0, 0, 0, 0);
    cycle(1, rand_instr(), 0, 0, 0, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    clear_model();
    check("midrst_valid", out_valid, 0);
    check("midrst_opr_a", out_opr_a, 0);
    check("midrst_opr_b", out_opr_b, 0);
    in_valid = 0; wb_en = 0; flush = 0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    cycle(1, 32'h0020_81B3, 1, 0, 0, 0, 0);
    check("postrst_a", out_opr_a, 0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom % 4) != 0, rand_instr(), ($urandom % 4) != 0, ($urandom % 16) == 0,
            1'($urandom), 5'($urandom), $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
